// File: rtl/avr_progmem_pkg.sv
// ---------------------------------------------------------------------------
// avr_progmem_pkg
// Shared definitions for the program-memory loader: loader FSM state
// encoding and the default frame start marker.
// ---------------------------------------------------------------------------
package avr_progmem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    CHECK   = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/avr_cpu_progmem_loader.sv
// ---------------------------------------------------------------------------
// avr_cpu_progmem_loader
// Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, 2*LEN data bytes,
// CHK), assembles little-endian 16-bit words and drives the write port of
// the CPU program memory. The CPU is held in reset from the start of a
// frame until a frame with a matching checksum completes.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts bytes (low only while in reset)
//   mem_we     out  one-cycle write strobe per assembled word
//   mem_waddr  out  word write address
//   mem_wdata  out  word write data {high byte, low byte}
//   cpu_hold   out  CPU reset request, active high
//   load_done  out  one-cycle pulse after a good frame
//   load_error out  sticky error, cleared by the next accepted SYNC byte
// ---------------------------------------------------------------------------
module avr_cpu_progmem_loader
  import avr_progmem_pkg::*;
#(
  parameter int         ADDR_WIDTH = 9,
  parameter int         MEM_SIZE   = 512,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [15:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  // One extra bit so that LEN == MEM_SIZE fits in the remaining-word count.
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_t                r_state,      w_state_next;
  logic                  r_rx_ready;
  logic [7:0]            r_len_lo,     w_len_lo_next;
  logic [CNT_W-1:0]      r_count,      w_count_next;
  logic [ADDR_WIDTH-1:0] r_addr,       w_addr_next;
  logic [7:0]            r_chk,        w_chk_next;
  logic [7:0]            r_data_lo,    w_data_lo_next;
  logic                  r_mem_we,     w_mem_we_next;
  logic [ADDR_WIDTH-1:0] r_mem_waddr,  w_mem_waddr_next;
  logic [15:0]           r_mem_wdata,  w_mem_wdata_next;
  logic                  r_cpu_hold,   w_cpu_hold_next;
  logic                  r_load_done,  w_load_done_next;
  logic                  r_load_error, w_load_error_next;

  logic                  w_accept;
  logic [15:0]           w_len;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_len    = {rx_data, r_len_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rx_ready   <= 1'b0;
      r_len_lo     <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      r_chk        <= '0;
      r_data_lo    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b1;   // program presumed invalid after reset
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rx_ready   <= 1'b1;
      r_len_lo     <= w_len_lo_next;
      r_count      <= w_count_next;
      r_addr       <= w_addr_next;
      r_chk        <= w_chk_next;
      r_data_lo    <= w_data_lo_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_waddr  <= w_mem_waddr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_cpu_hold   <= w_cpu_hold_next;
      r_load_done  <= w_load_done_next;
      r_load_error <= w_load_error_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_len_lo_next     = r_len_lo;
    w_count_next      = r_count;
    w_addr_next       = r_addr;
    w_chk_next        = r_chk;
    w_data_lo_next    = r_data_lo;
    w_mem_we_next     = 1'b0;
    w_mem_waddr_next  = r_mem_waddr;
    w_mem_wdata_next  = r_mem_wdata;
    w_cpu_hold_next   = r_cpu_hold;
    w_load_done_next  = 1'b0;
    w_load_error_next = r_load_error;

    if (w_accept) begin
      case (r_state)
        IDLE: begin
          // Anything other than the marker is line noise and is dropped.
          if (rx_data == SYNC_BYTE) begin
            w_cpu_hold_next   = 1'b1;
            w_load_error_next = 1'b0;
            w_addr_next       = '0;
            w_chk_next        = '0;
            w_state_next      = LEN_LO;
          end
        end
        LEN_LO: begin
          w_len_lo_next = rx_data;
          w_state_next  = LEN_HI;
        end
        LEN_HI: begin
          if (w_len > 16'(MEM_SIZE)) begin
            w_load_error_next = 1'b1;
            w_state_next      = IDLE;
          end else begin
            w_count_next = w_len[CNT_W-1:0];
            w_state_next = (w_len == 16'd0) ? CHECK : DATA_LO;
          end
        end
        DATA_LO: begin
          w_data_lo_next = rx_data;
          w_chk_next     = r_chk + rx_data;
          w_state_next   = DATA_HI;
        end
        DATA_HI: begin
          w_chk_next       = r_chk + rx_data;
          w_mem_we_next    = 1'b1;
          w_mem_waddr_next = r_addr;
          w_mem_wdata_next = {rx_data, r_data_lo};
          // After the last word of a MEM_SIZE frame this wraps, but it is
          // never used again before the next SYNC resets it.
          w_addr_next      = r_addr + 1'b1;
          w_count_next     = r_count - 1'b1;
          w_state_next     = (r_count == CNT_W'(1)) ? CHECK : DATA_LO;
        end
        CHECK: begin
          if (rx_data == r_chk) begin
            w_load_done_next = 1'b1;
            w_cpu_hold_next  = 1'b0;
          end else begin
            w_load_error_next = 1'b1;
          end
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_avr_cpu_progmem_loader.sv
// ---------------------------------------------------------------------------
// Testbench for avr_cpu_progmem_loader: directed frame table, hand-timed
// corner sequences, and random frames checked against a stream-level model.
// ---------------------------------------------------------------------------
module tb_avr_cpu_progmem_loader;

  localparam int AW = 9;
  localparam int MS = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  avr_cpu_progmem_loader #(.ADDR_WIDTH(AW), .MEM_SIZE(MS), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  // Observed (cumulative, written only by the monitor) and expected streams.
  wr_t got_q[$];
  wr_t exp_q[$];
  int  got_done = 0;
  int  exp_done = 0;
  int  cmp_g = 0;
  int  cmp_e = 0;
  int  cmp_done = 0;
  logic m_err  = 1'b0;
  logic m_hold = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_t e;
        e.addr = mem_waddr;
        e.data = mem_wdata;
        got_q.push_back(e);
      end
      if (load_done) got_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rx_data  = 8'($urandom_range(0, 255));
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] q[$], input bit gaps);
    foreach (q[k]) begin
      if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
      send_byte(q[k]);
    end
    repeat (3) idle_cycle();
  endtask

  // Stream-level reference: scan for frames and apply the framing rules
  // directly to the byte list.
  task automatic model_run(input logic [7:0] q[$]);
    int         i;
    logic [15:0] len;
    logic [7:0] sum;
    logic [7:0] lo;
    logic [7:0] hi;
    wr_t        e;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != 8'hA5) begin
        i++;
        continue;
      end
      m_hold = 1'b1;
      m_err  = 1'b0;
      len = {q[i+2], q[i+1]};
      i += 3;
      if (int'(len) > MS) begin
        m_err = 1'b1;
        continue;
      end
      sum = 8'h00;
      for (int w = 0; w < int'(len); w++) begin
        lo = q[i];
        hi = q[i+1];
        sum = sum + lo + hi;
        e.addr = AW'(w);
        e.data = {hi, lo};
        exp_q.push_back(e);
        i += 2;
      end
      if (q[i] == sum) begin
        exp_done++;
        m_hold = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      i++;
    end
  endtask

  task automatic compare_frame(input string tag);
    int n_new_g;
    int n_new_e;
    n_new_g = got_q.size() - cmp_g;
    n_new_e = exp_q.size() - cmp_e;
    check({tag, ".n_writes"}, 32'(n_new_g), 32'(n_new_e));
    for (int k = 0; k < n_new_g && k < n_new_e; k++) begin
      check({tag, ".waddr"}, 32'(got_q[cmp_g+k].addr), 32'(exp_q[cmp_e+k].addr));
      check({tag, ".wdata"}, 32'(got_q[cmp_g+k].data), 32'(exp_q[cmp_e+k].data));
    end
    cmp_g = got_q.size();
    cmp_e = exp_q.size();
    check({tag, ".done_pulses"}, 32'(got_done - cmp_done), 32'(exp_done - cmp_done));
    cmp_done = exp_done;
    check({tag, ".load_error"}, 32'(load_error), 32'(m_err));
    check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(m_hold));
  endtask

  typedef struct {
    logic [63:0] bytes;   // left-aligned, first byte in [63:56]
    int          n;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
    int          done;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [7:0] q[$];
    logic [7:0] sum;
    int         len;
    int         base_g;
    int         base_d;

    // Good load: checksum of 34 12 78 56 is 0x14 mod 256.
    tv[0] = '{64'hA5_02_00_34_12_78_56_14, 8, 2, 16'h1234, 16'h5678, 1, 1'b0, 1'b0};
    tv[1] = '{64'hA5_01_00_11_22_00_00_00, 6, 1, 16'h2211, 16'h0000, 0, 1'b1, 1'b1};
    tv[2] = '{64'hA5_01_02_00_00_00_00_00, 3, 0, 16'h0000, 16'h0000, 0, 1'b1, 1'b1};
    tv[3] = '{64'h00_FF_A5_00_00_00_00_00, 6, 0, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
    tv[4] = '{64'hA5_01_00_A5_A5_4A_00_00, 6, 1, 16'hA5A5, 16'h0000, 1, 1'b0, 1'b0};

    // Reset values while rst_n is low.
    repeat (3) @(posedge clk);
    #1;
    check("rst.rx_ready", 32'(rx_ready), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst.cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst.load_done", 32'(load_done), 32'd0);
    check("rst.load_error", 32'(load_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.rx_ready_after", 32'(rx_ready), 32'd1);

    // Directed frame table.
    for (int v = 0; v < 5; v++) begin
      logic [63:0] bb;
      q.delete();
      bb = tv[v].bytes;
      for (int k = 0; k < tv[v].n; k++) q.push_back(bb[63-8*k -: 8]);
      base_g = got_q.size();
      base_d = got_done;
      model_run(q);
      send_stream(q, 1'b0);
      check($sformatf("vec%0d.n_writes", v), 32'(got_q.size() - base_g), 32'(tv[v].nw));
      if (tv[v].nw >= 1 && got_q.size() > base_g) begin
        check($sformatf("vec%0d.w0_addr", v), 32'(got_q[base_g].addr), 32'd0);
        check($sformatf("vec%0d.w0_data", v), 32'(got_q[base_g].data), 32'(tv[v].w0));
      end
      if (tv[v].nw >= 2 && got_q.size() > base_g + 1) begin
        check($sformatf("vec%0d.w1_addr", v), 32'(got_q[base_g+1].addr), 32'd1);
        check($sformatf("vec%0d.w1_data", v), 32'(got_q[base_g+1].data), 32'(tv[v].w1));
      end
      check($sformatf("vec%0d.done", v), 32'(got_done - base_d), 32'(tv[v].done));
      check($sformatf("vec%0d.load_error", v), 32'(load_error), 32'(tv[v].err));
      check($sformatf("vec%0d.cpu_hold", v), 32'(cpu_hold), 32'(tv[v].hold));
      $display("vector %0d: %0d bytes sent, %0d writes seen", v, tv[v].n, got_q.size() - base_g);
    end
    cmp_g = got_q.size();
    cmp_e = exp_q.size();
    cmp_done = exp_done;

    // Oversize length: error appears right after the LEN_HI byte.
    send_byte(8'hA5);
    check("ovr.err_cleared_on_sync", 32'(load_error), 32'd0);
    check("ovr.hold_on_sync", 32'(cpu_hold), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    check("ovr.err_after_lenhi", 32'(load_error), 32'd1);
    q = '{8'hA5, 8'h01, 8'h02};
    model_run(q);
    repeat (2) idle_cycle();
    compare_frame("ovr");
    $display("oversize frame: load_error=%0b", load_error);

    // Reset in the middle of a frame, after the DATA_LO byte.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    rst_n = 1'b0;
    #1;
    check("mid.rx_ready", 32'(rx_ready), 32'd0);
    check("mid.cpu_hold", 32'(cpu_hold), 32'd1);
    check("mid.mem_waddr", 32'(mem_waddr), 32'd0);
    check("mid.mem_wdata", 32'(mem_wdata), 32'd0);
    check("mid.load_error", 32'(load_error), 32'd0);
    m_hold = 1'b1;
    m_err  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("mid-frame reset applied and released");

    // Next frame loads from 0, checked cycle by cycle for write and done timing.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hCD);
    check("tim.we_before_hi", 32'(mem_we), 32'd0);
    send_byte(8'hAB);
    check("tim.we_pulse", 32'(mem_we), 32'd1);
    check("tim.waddr", 32'(mem_waddr), 32'd0);
    check("tim.wdata", 32'(mem_wdata), 32'hABCD);
    send_byte(8'h78);
    check("tim.we_single", 32'(mem_we), 32'd0);
    check("tim.wdata_hold", 32'(mem_wdata), 32'hABCD);
    check("tim.done_pulse", 32'(load_done), 32'd1);
    check("tim.hold_fall", 32'(cpu_hold), 32'd0);
    @(posedge clk);
    #1;
    check("tim.done_single", 32'(load_done), 32'd0);
    q = '{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h78};
    model_run(q);
    repeat (2) idle_cycle();
    compare_frame("tim");
    $display("post-reset frame: write %04h@%0d", mem_wdata, mem_waddr);

    // Random frames against the stream model.
    for (int f = 0; f < 25; f++) begin
      logic [7:0] b;
      q.delete();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      q.push_back(8'hA5);
      if ($urandom_range(0, 9) == 0) begin
        len = int'($urandom_range(MS + 1, 65535));
        q.push_back(8'(len));
        q.push_back(8'(len >> 8));
      end else begin
        len = int'($urandom_range(0, 5));
        q.push_back(8'(len));
        q.push_back(8'h00);
        sum = 8'h00;
        for (int k = 0; k < 2 * len; k++) begin
          b = 8'($urandom_range(0, 255));
          sum = sum + b;
          q.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
        q.push_back(sum);
      end
      model_run(q);
      send_stream(q, 1'b1);
      compare_frame($sformatf("rnd%0d", f));
      $display("random frame %0d: len=%0d bytes=%0d err=%0b hold=%0b", f, len, q.size(), load_error, cpu_hold);
    end

    // Maximum length frame, back-to-back bytes.
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'(MS));
    q.push_back(8'(MS >> 8));
    sum = 8'h00;
    for (int k = 0; k < 2 * MS; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      sum = sum + b;
      q.push_back(b);
    end
    q.push_back(sum);
    model_run(q);
    send_stream(q, 1'b0);
    compare_frame("full");
    $display("full-size frame: %0d words, last addr %0d", MS, mem_waddr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
